// File: rtl/cond_predicate_unit.sv
// cond_predicate_unit
// ID-stage condition evaluator. It holds the NZCV status register and
// evaluates LANES condition codes per cycle. It also runs an IT-style
// sequencer that gives a predicate to each slot of a block of up to IT_MAX
// instructions.
//
// Handshake semantics: this block has no valid/ready pairs. Each control input
// is a single-cycle qualifier that is sampled at the rising clock edge.
// it_start asks for a new block to be loaded. it_advance retires the current
// slot. it_flush aborts the block. Priority is rst > it_flush >
// it_advance/it_start. it_err is a registered one-cycle pulse that reports a
// start request that was rejected.
module cond_predicate_unit #(
  parameter int LANES  = 2,
  parameter int IT_MAX = 4,
  parameter int BYPASS = 1,
  localparam int LW    = $clog2(IT_MAX + 1),
  localparam int IW    = $clog2(IT_MAX)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flags_we,
  input  logic [3:0]         flags_in,
  output logic [3:0]         flags_out,
  input  logic [4*LANES-1:0] cond_in,
  output logic [LANES-1:0]   cond_pass,
  input  logic               it_start,
  input  logic [3:0]         it_cond,
  input  logic [LW-1:0]      it_len,
  input  logic [IT_MAX-1:0]  it_te,
  input  logic               it_advance,
  input  logic               it_flush,
  output logic               it_active,
  output logic [LW-1:0]      it_remaining,
  output logic               it_pred,
  output logic               it_err
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  // The FSM state is kept in a named enum register so that checkers can bind to it.
  state_t             state_q, state_d;
  logic [3:0]         flags_q;
  logic [3:0]         cond_q, cond_d;
  logic [IT_MAX-1:0]  te_q, te_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [LW-1:0]      rem_q, rem_d;
  logic               err_q, err_d;
  logic [3:0]         eff;
  logic [3:0]         slot_cond;
  logic [IT_MAX-1:0]  te_mask;
  logic               start_legal;

  // Condition table. The flags are ordered {N,V,C,Z}. Code F is treated as always.
  function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] c);
    logic n, v, cf, z;
    logic r;
    n  = f[3];
    v  = f[2];
    cf = f[1];
    z  = f[0];
    case (c)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = cf;
      4'h3:    r = !cf;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = cf && !z;
      4'h9:    r = !cf || z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z && (n == v);
      4'hD:    r = z || (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Effective flags. When bypass is enabled, a write in this cycle is visible to this cycle's evaluations.
  always_comb begin
    eff = flags_q;
    if (BYPASS != 0 && flags_we) eff = flags_in;
  end

  // Per-lane condition evaluation
  always_comb begin
    cond_pass = '0;
    for (int i = 0; i < LANES; i++) begin
      cond_pass[i] = cond_eval(eff, cond_in[4*i +: 4]);
    end
  end

  // A start is legal if the length is in range, slot 0 is Then, and an AL/F base has no Else slot inside the block
  always_comb begin
    te_mask = '0;
    for (int k = 0; k < IT_MAX; k++) begin
      te_mask[k] = (LW'(k) < it_len);
    end
    start_legal = (it_len != '0) && (it_len <= LW'(IT_MAX)) && it_te[0] &&
                  ((it_cond[3:1] != 3'b111) || (&(it_te | ~te_mask)));
  end

  // Condition for the current slot. An Else slot flips the low bit of the code.
  always_comb begin
    slot_cond = te_q[idx_q] ? cond_q : (cond_q ^ 4'b0001);
  end

  // Sequencer next-state logic
  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    te_d    = te_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    if (it_flush) begin
      state_d = IDLE;
      idx_d   = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (it_start) begin
            if (start_legal) begin
              state_d = ACTIVE;
              cond_d  = it_cond;
              te_d    = it_te;
              idx_d   = '0;
              rem_d   = it_len;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ACTIVE: begin
          // IT blocks cannot be nested. A start while a block is active is rejected.
          if (it_start) err_d = 1'b1;
          if (it_advance) begin
            if (rem_q == LW'(1)) begin
              state_d = IDLE;
              idx_d   = '0;
              rem_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
              rem_d = rem_q - LW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cond_q  <= '0;
      te_q    <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      te_q    <= te_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Status register
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (flags_we) begin
      flags_q <= flags_in;
    end
  end

  // Outputs
  always_comb begin
    flags_out    = flags_q;
    it_active    = (state_q == ACTIVE);
    it_remaining = rem_q;
    it_err       = err_q;
    it_pred      = (state_q == ACTIVE) ? cond_eval(eff, slot_cond) : 1'b1;
  end

endmodule

// File: tb/tb_cond_predicate_unit.sv
// Bench for cond_predicate_unit. It drives one bypass instance and one
// registered-only instance from the same inputs. Both are checked against a
// flag/queue reference model.
module tb_cond_predicate_unit;
  localparam int LANES  = 2;
  localparam int IT_MAX = 4;
  localparam int LW     = $clog2(IT_MAX + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               flags_we;
  logic [3:0]         flags_in;
  logic [4*LANES-1:0] cond_in;
  logic               it_start;
  logic [3:0]         it_cond;
  logic [LW-1:0]      it_len;
  logic [IT_MAX-1:0]  it_te;
  logic               it_advance;
  logic               it_flush;

  logic [3:0]         flags_out_b, flags_out_n;
  logic [LANES-1:0]   cond_pass_b, cond_pass_n;
  logic               it_active_b, it_active_n;
  logic [LW-1:0]      it_remaining_b, it_remaining_n;
  logic               it_pred_b, it_pred_n;
  logic               it_err_b, it_err_n;

  cond_predicate_unit #(.LANES(LANES), .IT_MAX(IT_MAX), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .flags_we(flags_we), .flags_in(flags_in), .flags_out(flags_out_b),
    .cond_in(cond_in), .cond_pass(cond_pass_b), .it_start(it_start), .it_cond(it_cond),
    .it_len(it_len), .it_te(it_te), .it_advance(it_advance), .it_flush(it_flush),
    .it_active(it_active_b), .it_remaining(it_remaining_b), .it_pred(it_pred_b), .it_err(it_err_b)
  );

  cond_predicate_unit #(.LANES(LANES), .IT_MAX(IT_MAX), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .flags_we(flags_we), .flags_in(flags_in), .flags_out(flags_out_n),
    .cond_in(cond_in), .cond_pass(cond_pass_n), .it_start(it_start), .it_cond(it_cond),
    .it_len(it_len), .it_te(it_te), .it_advance(it_advance), .it_flush(it_flush),
    .it_active(it_active_n), .it_remaining(it_remaining_n), .it_pred(it_pred_n), .it_err(it_err_n)
  );

  // ---------------- reference model / scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] m_flags = 4'h0;
  logic [3:0] exp_q[$];      // slot conditions still to be issued in the current block
  logic       m_err   = 1'b0;

  // Evaluate a condition code from its pair (bits 3:1) and its invert bit (bit 0)
  function automatic logic ref_eval(input logic [3:0] f, input logic [3:0] c);
    logic n, v, cf, z, r;
    n = f[3]; v = f[2]; cf = f[1]; z = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) r = ~r;
    return r;
  endfunction

  function automatic logic [3:0] eff_flags(input logic bypass);
    return (bypass && flags_we) ? flags_in : m_flags;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against the model
  task automatic check_all(input string tag);
    logic [LANES-1:0] cp_b, cp_n;
    logic pr_b, pr_n;
    for (int i = 0; i < LANES; i++) begin
      cp_b[i] = ref_eval(eff_flags(1'b1), cond_in[4*i +: 4]);
      cp_n[i] = ref_eval(eff_flags(1'b0), cond_in[4*i +: 4]);
    end
    pr_b = (exp_q.size() == 0) ? 1'b1 : ref_eval(eff_flags(1'b1), exp_q[0]);
    pr_n = (exp_q.size() == 0) ? 1'b1 : ref_eval(eff_flags(1'b0), exp_q[0]);
    chk({tag, ".flags_b"}, 8'(flags_out_b), 8'(m_flags));
    chk({tag, ".flags_n"}, 8'(flags_out_n), 8'(m_flags));
    chk({tag, ".pass_b"}, 8'(cond_pass_b), 8'(cp_b));
    chk({tag, ".pass_n"}, 8'(cond_pass_n), 8'(cp_n));
    chk({tag, ".pred_b"}, 8'(it_pred_b), 8'(pr_b));
    chk({tag, ".pred_n"}, 8'(it_pred_n), 8'(pr_n));
    chk({tag, ".active"}, 8'({it_active_n, it_active_b}), {6'd0, {2{exp_q.size() != 0}}});
    chk({tag, ".rem_b"}, 8'(it_remaining_b), 8'(exp_q.size()));
    chk({tag, ".rem_n"}, 8'(it_remaining_n), 8'(exp_q.size()));
    chk({tag, ".err"}, 8'({it_err_n, it_err_b}), {6'd0, m_err, m_err});
  endtask

  // Update the model for the coming clock edge from the current inputs
  task automatic model_edge();
    logic [3:0] tmp[$];
    logic legal;
    if (rst) begin
      m_flags = 4'h0;
      exp_q.delete();
      m_err = 1'b0;
    end else begin
      if (flags_we) m_flags = flags_in;
      m_err = 1'b0;
      if (it_flush) begin
        exp_q.delete();
      end else if (exp_q.size() != 0) begin
        if (it_start) m_err = 1'b1;
        if (it_advance) void'(exp_q.pop_front());
      end else if (it_start) begin
        legal = (it_len >= 1) && (it_len <= IT_MAX) && it_te[0];
        if (legal) begin
          for (int k = 0; k < int'(it_len); k++) begin
            if (it_cond >= 4'hE && !it_te[k]) legal = 1'b0;
            tmp.push_back(it_te[k] ? it_cond : (it_cond ^ 4'h1));
          end
        end
        if (legal) exp_q = tmp;
        else m_err = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ins();
    rst = 0; flags_we = 0; flags_in = 0; it_start = 0; it_cond = 0;
    it_len = 0; it_te = 0; it_advance = 0; it_flush = 0;
  endtask

  task automatic start_block(input logic [3:0] c, input logic [LW-1:0] l, input logic [IT_MAX-1:0] te);
    it_start = 1; it_cond = c; it_len = l; it_te = te;
    tick();
    it_start = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_ins();
    cond_in = 8'h10;
    rst = 1;
    tick();
    rst = 0;
    check_all("reset");
    chk("reset.pred", 8'(it_pred_b), 8'd1);
    chk("reset.eq_ne", 8'(cond_pass_b), 8'b10);

    // Full table sweep over all flag values and codes on both lanes
    for (int f = 0; f < 16; f++) begin
      flags_we = 1; flags_in = 4'(f);
      tick();
      flags_we = 0;
      for (int c = 0; c < 16; c++) begin
        cond_in = {4'(15 - c), 4'(c)};
        #1;
        check_all("sweep");
      end
    end
    flags_we = 1; flags_in = 4'b1001;
    tick();
    flags_we = 0;
    cond_in = {4'hC, 4'hD};
    #1;
    chk("n_z.le_gt", 8'(cond_pass_n), 8'b01);
    cond_in = {4'h4, 4'h4};
    #1;
    chk("n_z.mi", 8'(cond_pass_n), 8'b11);

    // Same-cycle bypass compared with registered-only flags
    flags_we = 1; flags_in = 4'h0;
    tick();
    cond_in = 8'h00;
    flags_in = 4'b0001;
    #1;
    check_all("bypass.same");
    chk("bypass.b", 8'(cond_pass_b), 8'b11);
    chk("bypass.n", 8'(cond_pass_n), 8'b00);
    tick();
    flags_we = 0;
    #1;
    check_all("bypass.next");
    chk("bypass.n_next", 8'(cond_pass_n), 8'b11);

    // IT block EQ, len 3, Then/Else/Then, with Z set
    start_block(4'h0, 3'd3, 4'b1101);
    check_all("it.s0");
    chk("it.rem0", 8'(it_remaining_b), 8'd3);
    chk("it.pred0", 8'(it_pred_b), 8'd1);
    it_advance = 1;
    tick();
    check_all("it.s1");
    chk("it.pred1", 8'(it_pred_b), 8'd0);
    chk("it.rem1", 8'(it_remaining_b), 8'd2);
    tick();
    check_all("it.s2");
    chk("it.pred2", 8'(it_pred_b), 8'd1);
    tick();
    it_advance = 0;
    check_all("it.done");
    chk("it.active_end", 8'(it_active_b), 8'd0);

    // Illegal starts
    start_block(4'h0, 3'd0, 4'b0001);
    check_all("ill.len0");
    chk("ill.len0.err", 8'(it_err_b), 8'd1);
    tick();
    check_all("ill.len0.clr");
    start_block(4'h0, 3'd2, 4'b0010);
    check_all("ill.te0");
    start_block(4'hE, 3'd2, 4'b0001);
    check_all("ill.al");
    chk("ill.al.err", 8'(it_err_b), 8'd1);
    start_block(4'h1, 3'd5, 4'b1111);
    check_all("ill.len5");
    start_block(4'hE, 3'd2, 4'b0011);
    check_all("al.ok");
    chk("al.ok.active", 8'(it_active_b), 8'd1);
    it_flush = 1;
    tick();
    it_flush = 0;
    start_block(4'h2, 3'd3, 4'b0001);
    start_block(4'h3, 3'd2, 4'b0011);
    check_all("ill.nest");
    chk("ill.nest.err", 8'(it_err_b), 8'd1);
    chk("ill.nest.rem", 8'(it_remaining_b), 8'd3);
    // A start arriving together with the final advance is rejected as well
    it_advance = 1;
    tick();
    tick();
    it_start = 1; it_cond = 4'h0; it_len = 3'd2; it_te = 4'b0001;
    tick();
    it_start = 0; it_advance = 0;
    check_all("ill.last");
    chk("ill.last.err", 8'(it_err_b), 8'd1);

    // Flush arriving together with an advance, in the middle of a block
    start_block(4'h1, 3'd4, 4'b1111);
    it_advance = 1;
    tick();
    it_flush = 1;
    tick();
    it_flush = 0; it_advance = 0;
    check_all("flush");
    chk("flush.pred", 8'(it_pred_b), 8'd1);
    chk("flush.err", 8'(it_err_b), 8'd0);

    // Synchronous reset in the middle of a block
    flags_we = 1; flags_in = 4'hF;
    start_block(4'h4, 3'd4, 4'b0101);
    flags_we = 0;
    rst = 1;
    #2;
    rst = 0;
    #1;
    check_all("rst.noedge");
    rst = 1; it_start = 1; it_cond = 4'h0; it_len = 3'd1; it_te = 4'b0001;
    tick();
    rst = 0; it_start = 0;
    check_all("rst.edge");
    chk("rst.flags", 8'(flags_out_b), 8'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      flags_we   = 1'($urandom_range(0, 1));
      flags_in   = 4'($urandom);
      cond_in    = 8'($urandom);
      it_start   = ($urandom_range(0, 3) == 0);
      it_cond    = 4'($urandom);
      it_len     = 3'($urandom_range(0, 5));
      it_te      = 4'($urandom) | 4'($urandom_range(0, 7) != 0);
      it_advance = 1'($urandom_range(0, 1));
      it_flush   = ($urandom_range(0, 15) == 0);
      #1;
      check_all("rnd.comb");
      tick();
      check_all("rnd.seq");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_predicate_unit.md
Name: cond_predicate_unit

Overview:
- Next-generation condition evaluator for the ID stage.
- Owns the NZCV status register and evaluates LANES condition codes per cycle, with optional same-cycle flag bypass.
- Adds an IT-style predication sequencer that supplies a per-instruction predicate for a block of up to IT_MAX following instructions.
- Sits between the status-register write port from EXE and the ID-stage issue/kill logic.

Parameters:
LANES, 2, number of independent condition queries evaluated per cycle
IT_MAX, 4, maximum instructions covered by one IT block (2..8)
BYPASS, 1, 1 = evaluate against flags_in when flags_we is high in the same cycle; 0 = use registered flags only

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flags_we  in  1  status register write enable (S bit from EXE)
flags_in  in  4  new flags {N,V,C,Z} = bits [3:0] as N=3, V=2, C=1, Z=0
flags_out  out  4  registered status register
cond_in  in  4*LANES  lane i condition at bits [4i+3:4i]
cond_pass  out  LANES  combinational pass result per lane
it_start  in  1  load a new IT block this cycle
it_cond  in  4  base condition of the block
it_len  in  clog2(IT_MAX+1)  block length, 1..IT_MAX
it_te  in  IT_MAX  bit k: 1 = slot k uses it_cond (Then), 0 = inverted (Else); bit 0 must be 1
it_advance  in  1  current predicated instruction consumed
it_flush  in  1  pipeline flush; abort block
it_active  out  1  block in progress
it_remaining  out  clog2(IT_MAX+1)  slots left, including current
it_pred  out  1  predicate for current slot; 1 when idle
it_err  out  1  one-cycle registered pulse on an illegal start

Behaviour:
- Condition table, 4-bit code:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F treated as 1
- Effective flags:
  - eff = flags_in when BYPASS=1 and flags_we=1; otherwise flags_out.
  - All cond_pass and it_pred use eff, combinationally, with zero latency.
- Status register: flags_out <= flags_in at the clock edge when flags_we; otherwise holds.
- Inverted condition: slot cond = it_cond ^ 4'b0001 when it_te[k]=0.
- FSM states: IDLE, ACTIVE. Internal regs: base cond, len, te, slot index idx.
- IDLE:
  - Legal it_start -> ACTIVE with idx=0, it_remaining=it_len, it_active=1 from the next cycle.
  - A start is illegal when any of these hold:
    - it_len==0 or it_len>IT_MAX
    - it_te[0]==0
    - it_cond in {E,F} while any te bit k<it_len is 0
  - Illegal start: stay IDLE, it_err=1 next cycle.
- ACTIVE:
  - it_pred = eval(slot cond of idx).
  - it_advance: idx+1 and it_remaining-1; when it_remaining==1, go to IDLE and set it_remaining=0.
  - it_start while ACTIVE: ignored (no nesting), it_err pulses.
  - Simultaneous it_start and it_advance on the last slot: block ends and the start is also ignored with it_err.
- it_te bits at index >= it_len are don't-care.
- Priority: rst > it_flush > it_advance/it_start.
  - it_flush in any state: next state IDLE, it_remaining=0, no it_err, flags unaffected.
- Flags written in the same cycle as an active slot are visible to that slot's it_pred when BYPASS=1.
- Reset (synchronous): flags_out=0, IDLE, idx=0, it_remaining=0, it_active=0, it_err=0.
- After reset with zero flags: it_pred=1, and cond_pass follows the zero flags (e.g. EQ=0, NE=1, AL=1).
- Reset asserted mid-block aborts the block with no it_err.

Test Plan:
1. Table sweep, BYPASS=0: for all 16 flag values, write via flags_we, then drive all 16 codes on lane 0 and lane 1 next cycle -> cond_pass matches the table; e.g. flags 4'b1001 (N,Z): LE=1, GT=0, MI=1.
2. Bypass: flags_out=0, drive flags_we=1, flags_in=4'b0001, cond EQ -> cond_pass=1 in the same cycle; with BYPASS=0 -> 0 that cycle, 1 the next.
3. IT block: flags Z=1, it_start with cond=EQ, len=3, te=3'b101, then advance each cycle -> it_pred 1,0,1, it_remaining 3,2,1, it_active drops after the 3rd advance.
4. Illegal starts:
   - len=0 -> it_err pulse, it_active=0.
   - te[0]=0 -> it_err pulse, it_active=0.
   - cond=AL with te=2'b01, len=2 -> it_err pulse, it_active=0.
   - Start during ACTIVE -> it_err pulse and remaining count unchanged.
5. Flush mid-block: start len=4, advance once, assert it_flush together with it_advance -> next cycle it_active=0, it_remaining=0, it_pred=1, no it_err.
6. Synchronous reset mid-block with flags=4'b1111 -> next edge flags_out=0, it_active=0; a reset pulse without a clock edge does not change state.
